fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, address/PC width.
REQ-002 Parameter DEPTH, default 4, instruction FIFO entries (power of 2, >=2).
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 Parameter OFF_W, default 12, branch word-offset width.
REQ-005 Parameter EXC_VECTOR, default 32'h0000_0180, exception target (used only with FETCH_EXC_EN).
REQ-006 Port list SHALL be, in order:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- imem_req_valid  out  1  fetch request.
- imem_req_addr  out  XLEN  fetch address.
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  response data valid.
- imem_rsp_data  in  32  instruction word.
- dec_valid  out  1  instruction offered to decode.
- dec_inst  out  32  instruction.
- dec_pc  out  XLEN  address of dec_inst.
- dec_ready  in  1  decode accepts.
- br_taken  in  1  taken-branch redirect.
- br_pc  in  XLEN  PC of the branch.
- br_off  in  OFF_W  signed word offset.
- jmp_valid  in  1  jump redirect.
- jmp_target  in  XLEN  jump target.
- exc_valid  in  1  exception (FETCH_EXC_EN only).
- epc  out  XLEN  captured exception PC (FETCH_EXC_EN only).

Function
REQ-007 FSM states SHALL be S_REQ, S_WAIT, S_DRAIN; at most one request outstanding.
REQ-008 S_REQ: imem_req_valid=1 only when FIFO occupancy < DEPTH; on valid&&ready, go to S_WAIT and advance fetch PC by 4.
REQ-009 S_WAIT: on imem_rsp_valid, push {imem_rsp_data, request addr} into FIFO, then go to S_REQ the same edge.
REQ-010 S_DRAIN: next imem_rsp_valid SHALL be discarded (not pushed), then go to S_REQ.
REQ-011 dec_valid SHALL equal FIFO non-empty; pop on dec_valid&&dec_ready; push and pop in the same cycle SHALL be allowed when full.
REQ-012 Branch target SHALL be br_pc + 4 + (sign_extend(br_off) << 2), computed at XLEN modulo 2^XLEN.
REQ-013 Jump target SHALL be jmp_target with bits [1:0] forced to 0.
REQ-014 Redirect priority SHALL be exc_valid > jmp_valid > br_taken; the highest asserted one wins.
REQ-015 On redirect: FIFO flushed (dec_valid=0 next cycle), fetch PC loaded with target; if in S_WAIT without same-cycle response, go to S_DRAIN; else go to S_REQ.
REQ-016 A response arriving in the same cycle as a redirect SHALL be discarded.
REQ-017 Redirect in the same cycle as a request handshake SHALL cancel that request (treated as outstanding, state S_DRAIN).
REQ-018 First request after reset SHALL use RESET_PC, issued the first cycle rst is low.

Reset
REQ-019 While rst high: imem_req_valid=0, dec_valid=0, FIFO empty, state S_REQ, fetch PC=RESET_PC, epc=0.
REQ-020 rst mid-transaction SHALL abandon the outstanding request; its late response (while rst low, state S_REQ) SHALL be ignored.

Configuration
REQ-021 Macro FETCH_EXC_EN: defined -> exc_valid redirects to EXC_VECTOR and epc captures dec_pc of the FIFO head (RESET_PC if empty) on that edge; undefined -> exc_valid and epc ports absent, no exception logic.

Structure
REQ-022 Shared package fetch_pkg SHALL hold the state enum, the FIFO entry type {inst, pc} and EXC_VECTOR default.
REQ-023 FIFO SHALL be a sub-module fetch_fifo (DEPTH, width 32+XLEN, flush input).

Verification
REQ-024 Reset release, memory ready/1-cycle latency, dec_ready=1 -> dec_pc sequence 0,4,8,12.
REQ-025 dec_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 pushes, imem_req_valid=0 thereafter, no loss after release.
REQ-026 Branch br_pc=0x20, br_off=-3 -> next fetch addr 0x18, older FIFO entries flushed.
REQ-027 jmp_valid, jmp_target=0x103 during S_WAIT -> stale response dropped, next request addr 0x100.
REQ-028 jmp_valid and br_taken same cycle -> jump target wins.
REQ-029 FETCH_EXC_EN, exc_valid with head pc 0x40 -> epc=0x40, next request addr 0x180.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DRAIN
    } fetch_state_t;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0180;

    // Entry layout for the default 32-bit PC; wider builds keep the same {inst, pc} order.
    localparam int PKG_XLEN = 32;

    typedef struct packed {
        logic [31:0]         inst;
        logic [PKG_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory and decode handshake bundle around fetch_unit.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            dec_valid;
    logic [31:0]     dec_inst;
    logic [XLEN-1:0] dec_pc;
    logic            dec_ready;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output dec_valid, dec_inst, dec_pc,
        input  dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  dec_valid, dec_inst, dec_pc,
        output dec_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Instruction FIFO with first-word-fall-through head and single-cycle flush.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push, do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    // Head is read combinationally so decode sees it in the cycle it lands.
    assign dout = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch with branch/jump redirect and decode FIFO.
// Build macro FETCH_EXC_EN adds the exception redirect and the epc capture port.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              DEPTH      = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              OFF_W      = 12,
    parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(EXC_VECTOR_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic             dec_valid,
    output logic [31:0]      dec_inst,
    output logic [XLEN-1:0]  dec_pc,
    input  logic             dec_ready,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  br_pc,
    input  logic [OFF_W-1:0] br_off,
    input  logic             jmp_valid,
    input  logic [XLEN-1:0]  jmp_target
`ifdef FETCH_EXC_EN
    ,
    input  logic             exc_valid,
    output logic [XLEN-1:0]  epc
`endif
);
    localparam int W = 32 + XLEN;

    fetch_state_t    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] req_addr_reg, req_addr_next;
    logic [XLEN-1:0] br_target, redir_target;
    logic            redir, req_fire, push, pop;
    logic            fifo_empty, fifo_full;
    logic [W-1:0]    fifo_dout;

    assign br_target = br_pc + XLEN'(4) + (XLEN'($signed(br_off)) << 2);

`ifdef FETCH_EXC_EN
    logic [XLEN-1:0] epc_reg;

    assign redir        = exc_valid || jmp_valid || br_taken;
    assign redir_target = exc_valid ? EXC_VECTOR :
                          jmp_valid ? (jmp_target & ~XLEN'(3)) : br_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            epc_reg <= '0;
        end else if (exc_valid) begin
            epc_reg <= fifo_empty ? RESET_PC : fifo_dout[XLEN-1:0];
        end
    end
    assign epc = epc_reg;
`else
    logic unused_exc_vector;

    assign unused_exc_vector = ^EXC_VECTOR;
    assign redir        = jmp_valid || br_taken;
    assign redir_target = jmp_valid ? (jmp_target & ~XLEN'(3)) : br_target;
`endif

    assign imem_req_valid = !rst && (state_reg == S_REQ) && !fifo_full;
    assign imem_req_addr  = pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign dec_valid = !rst && !fifo_empty;
    assign dec_inst  = fifo_dout[W-1:XLEN];
    assign dec_pc    = fifo_dout[XLEN-1:0];
    assign pop       = dec_valid && dec_ready;

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        req_addr_next = req_addr_reg;
        push          = 1'b0;
        case (state_reg)
            S_REQ: begin
                if (req_fire) begin
                    // A request accepted alongside a redirect is still in flight in memory.
                    state_next    = redir ? S_DRAIN : S_WAIT;
                    req_addr_next = pc_reg;
                    pc_next       = pc_reg + XLEN'(4);
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_next = S_REQ;
                    push       = !redir;
                end else if (redir) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_rsp_valid) state_next = S_REQ;
            end
            default: state_next = S_REQ;
        endcase
        if (redir) pc_next = redir_target;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_REQ;
            pc_reg       <= RESET_PC;
            req_addr_reg <= RESET_PC;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            req_addr_reg <= req_addr_next;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redir),
        .push  (push),
        .din   ({imem_rsp_data, req_addr_reg}),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: random memory/decode timing, expected stream from redirect rules.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam int          OFF_W    = 12;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(XLEN)) bus();

    logic              br_taken, jmp_valid;
    logic [XLEN-1:0]   br_pc, jmp_target;
    logic [OFF_W-1:0]  br_off;
`ifdef FETCH_EXC_EN
    logic              exc_valid;
    logic [XLEN-1:0]   epc;
`endif

    fetch_unit #(
        .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .OFF_W(OFF_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (bus.imem_req_valid),
        .imem_req_addr  (bus.imem_req_addr),
        .imem_req_ready (bus.imem_req_ready),
        .imem_rsp_valid (bus.imem_rsp_valid),
        .imem_rsp_data  (bus.imem_rsp_data),
        .dec_valid      (bus.dec_valid),
        .dec_inst       (bus.dec_inst),
        .dec_pc         (bus.dec_pc),
        .dec_ready      (bus.dec_ready),
        .br_taken       (br_taken),
        .br_pc          (br_pc),
        .br_off         (br_off),
        .jmp_valid      (jmp_valid),
        .jmp_target     (jmp_target)
`ifdef FETCH_EXC_EN
        ,
        .exc_valid      (exc_valid),
        .epc            (epc)
`endif
    );

    int tests = 0;
    int fails = 0;

    fetch_entry_t exp_q[$];
    logic [31:0]  model_target;
    logic [31:0]  req_exp;
    logic [31:0]  epc_exp;
    bit           req_chk   = 1'b0;
    bit           chk_empty = 1'b0;
    bit           chk_epc   = 1'b0;
    int           hs_count  = 0;
    int           cyc       = 0;

    int ready_pct  = 100;
    int lat_min    = 1;
    int lat_max    = 1;
    bit hold_ready = 1'b0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Expected decode stream after a reset or redirect: sequential words from the target.
    task automatic load_stream(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 400; i++) begin
            fetch_entry_t e;
            e.pc   = start + 32'(i * 4);
            e.inst = mem_word(e.pc);
            exp_q.push_back(e);
        end
    endtask

    // Memory model: variable ready, response latency lat_min..lat_max cycles.
    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            bit          hs, fire;
            logic [31:0] a;
            pend_t       p;
            @(negedge clk);
            hs   = bus.imem_req_valid && bus.imem_req_ready;
            a    = bus.imem_req_addr;
            fire = bus.imem_rsp_valid;
            @(posedge clk);
            #1;
            cyc++;
            if (fire) void'(pend_q.pop_front());
            if (hs) begin
                p.addr = a;
                p.due  = cyc + int'($urandom_range(lat_max, lat_min)) - 1;
                pend_q.push_back(p);
            end
            if (pend_q.size() > 0 && cyc >= pend_q[0].due) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(pend_q[0].addr);
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = $urandom;
            end
            bus.imem_req_ready = !hold_ready && (int'($urandom_range(99, 0)) < ready_pct);
        end
    end

    // Monitor: pops the scoreboard on every decode handshake, checks redirect effects.
    initial begin
        forever begin
            fetch_entry_t e;
            bit           redir_now;
            @(negedge clk);
            if (rst) begin
                chk_empty = 1'b0;
                check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
                check("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
`ifdef FETCH_EXC_EN
                check("rst_epc", epc, 32'd0);
`endif
            end else begin
                if (chk_empty) begin
                    check("flush_dec_valid", 32'(bus.dec_valid), 32'd0);
                    chk_empty = 1'b0;
                end
`ifdef FETCH_EXC_EN
                if (chk_epc) begin
                    check("epc", epc, epc_exp);
                    chk_epc = 1'b0;
                end
`endif
                if (bus.dec_valid && bus.dec_ready) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL dec_unexpected: actual pc 0x%08h required no output", bus.dec_pc);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.dec_pc !== e.pc || bus.dec_inst !== e.inst) begin
                            fails++;
                            $display("FAIL dec_entry: actual pc 0x%08h inst 0x%08h required pc 0x%08h inst 0x%08h",
                                     bus.dec_pc, bus.dec_inst, e.pc, e.inst);
                        end else begin
                            $display("[TB] dec pc=0x%08h inst=0x%08h", e.pc, e.inst);
                        end
                    end
                end
                redir_now = br_taken || jmp_valid;
`ifdef FETCH_EXC_EN
                redir_now = redir_now || exc_valid;
                if (exc_valid) chk_epc = 1'b1;
`endif
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    hs_count++;
                    if (!redir_now && req_chk) begin
                        check("req_addr", bus.imem_req_addr, req_exp);
                        req_chk = 1'b0;
                    end
                end
                if (redir_now) begin
                    req_chk   = 1'b1;
                    req_exp   = model_target;
                    chk_empty = 1'b1;
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that took the redirect.
    task automatic do_redirect(input bit b, input bit j, input bit e,
                               input logic [31:0] bpc, input logic [OFF_W-1:0] boff,
                               input logic [31:0] jt);
        int          o;
        logic [31:0] t;
        o = int'(boff);
        if (boff[OFF_W-1]) o = o - (1 << OFF_W);
        if (e)      t = 32'h0000_0180;
        else if (j) t = jt & 32'hFFFF_FFFC;
        else        t = bpc + 32'd4 + 32'(o * 4);
        model_target = t;
        br_taken     = b;
        br_pc        = bpc;
        br_off       = boff;
        jmp_valid    = j;
        jmp_target   = jt;
`ifdef FETCH_EXC_EN
        exc_valid    = e;
`endif
        $display("[TB] redirect br=%0d jmp=%0d exc=%0d target=0x%08h", b, j, e, t);
        @(negedge clk);
        #1;
        load_stream(t);
        @(posedge clk);
        #1;
        br_taken  = 1'b0;
        jmp_valid = 1'b0;
`ifdef FETCH_EXC_EN
        exc_valid = 1'b0;
`endif
    endtask

    task automatic wait_hs();
        int h;
        h = hs_count;
        for (int i = 0; i < 60 && hs_count == h; i++) @(posedge clk);
        tests++;
        if (hs_count == h) begin
            fails++;
            $display("FAIL wait_hs: actual no request handshake required one within 60 cycles");
        end
        #1;
    endtask

    task automatic run(input int n, input bit rnd_ready);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rnd_ready) bus.dec_ready = $urandom_range(1, 0);
        end
    endtask

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: actual timeout required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        rst           = 1'b1;
        br_taken      = 1'b0;
        jmp_valid     = 1'b0;
        br_pc         = '0;
        br_off        = '0;
        jmp_target    = '0;
        bus.dec_ready = 1'b1;
        model_target  = '0;
        req_exp       = '0;
        epc_exp       = '0;
`ifdef FETCH_EXC_EN
        exc_valid     = 1'b0;
`endif
        load_stream(RESET_PC);
        repeat (3) @(posedge clk);
        #1;
        rst     = 1'b0;
        req_exp = RESET_PC;
        req_chk = 1'b1;
        @(negedge clk);
        check("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("first_req_addr", bus.imem_req_addr, RESET_PC);

        // Ideal memory, decode always ready: stream 0,4,8,12,...
        run(20, 1'b0);

        ready_pct = 60; lat_min = 1; lat_max = 3;
        run(200, 1'b1);

        // Fill the FIFO, then branch 0x20 + 4 - 12 = 0x18.
        bus.dec_ready = 1'b0;
        run(14, 1'b0);
        do_redirect(1'b1, 1'b0, 1'b0, 32'h20, OFF_W'(-3), 32'h0);
        bus.dec_ready = 1'b1;
        run(30, 1'b0);

        // Jump while waiting on memory: stale response must not reach decode.
        ready_pct = 100; lat_min = 3; lat_max = 3;
        wait_hs();
        do_redirect(1'b0, 1'b1, 1'b0, 32'h0, '0, 32'h103);
        run(30, 1'b0);

        // Jump and branch together: jump wins.
        do_redirect(1'b1, 1'b1, 1'b0, 32'h50, OFF_W'(5), 32'h200);
        run(30, 1'b0);

        // Decode stalled: exactly DEPTH fetches, then requests stop.
        lat_min = 1; lat_max = 1;
        bus.dec_ready = 1'b0;
        do_redirect(1'b0, 1'b1, 1'b0, 32'h0, '0, 32'h300);
        h0 = hs_count;
        run(16, 1'b0);
        @(negedge clk);
        check("stall_fetch_count", 32'(hs_count - h0), 32'(DEPTH));
        check("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("stall_dec_valid", 32'(bus.dec_valid), 32'd1);
        @(posedge clk);
        #1;
        bus.dec_ready = 1'b1;
        run(30, 1'b0);

        ready_pct = 70; lat_min = 1; lat_max = 3;
        for (int k = 0; k < 25; k++) begin
            int kind;
            run($urandom_range(8, 0), 1'b1);
            kind = $urandom_range(2, 0);
            do_redirect(kind != 1, kind != 0, 1'b0, $urandom & 32'hFFFF_FFFC,
                        OFF_W'($urandom), $urandom);
        end
        run(40, 1'b1);

        // Reset during an outstanding request; its late response must be ignored.
        bus.dec_ready = 1'b1;
        ready_pct = 100; lat_min = 5; lat_max = 5;
        wait_hs();
        hold_ready = 1'b1;
        rst = 1'b1;
        load_stream(RESET_PC);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst     = 1'b0;
        req_exp = RESET_PC;
        req_chk = 1'b1;
        @(negedge clk);
        check("rearm_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("rearm_req_addr", bus.imem_req_addr, RESET_PC);
        for (int i = 0; i < 30 && pend_q.size() != 0; i++) @(posedge clk);
        check("late_rsp_delivered", 32'(pend_q.size()), 32'd0);
        @(posedge clk); #1;
        hold_ready = 1'b0;
        lat_min = 1; lat_max = 2;
        run(40, 1'b0);

`ifdef FETCH_EXC_EN
        // Exception with head pc 0x40, then again with an empty FIFO.
        lat_min = 1; lat_max = 1;
        bus.dec_ready = 1'b0;
        do_redirect(1'b0, 1'b1, 1'b0, 32'h0, '0, 32'h40);
        for (int i = 0; i < 40 && !bus.dec_valid; i++) @(negedge clk);
        check("exc_head_ready", 32'(bus.dec_valid), 32'd1);
        @(posedge clk); #1;
        epc_exp = 32'h40;
        do_redirect(1'b0, 1'b0, 1'b1, 32'h0, '0, 32'h0);
        epc_exp = RESET_PC;
        do_redirect(1'b0, 1'b0, 1'b1, 32'h0, '0, 32'h0);
        bus.dec_ready = 1'b1;
        run(30, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
